fifo_wr_arbiter: RTL

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that lets N_REQ requesters share one
// FIFO write port. The winner owns the port for up to BURST beats. Write
// enable and data toward the FIFO are registered. The almost-full flag is
// combined with the write already in flight, so the FIFO never overflows.
module fifo_wr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int BURST      = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ*FIFO_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]              gnt,
  input  logic                          fifo_full,
  input  logic                          fifo_almostfull,
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  output logic [15:0]                   stall_cnt,
  output logic [2:0]                    owner_id
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            owner_q, owner_d;
  logic [2:0]            rr_ptr_q, rr_ptr_d;
  logic [3:0]            beat_cnt_q, beat_cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic [FIFO_WIDTH-1:0] data_q, data_d;
  logic [15:0]           stall_cnt_q, stall_cnt_d;

  // Per-requester views of the packed inputs.
  logic [FIFO_WIDTH-1:0] slice [N_REQ];
  logic [N_REQ-1:0]      owner_oh;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign slice[gi]    = req_data[gi*FIFO_WIDTH +: FIFO_WIDTH];
      assign owner_oh[gi] = (owner_q == 3'(gi));
    end
  endgenerate

  logic                  owner_req;
  logic [FIFO_WIDTH-1:0] owner_data;
  logic                  stall;
  logic                  xfer;
  logic                  last_beat;
  logic [2:0]            owner_next;

  // Select the owner's request bit and data beat without a variable index.
  always_comb begin
    owner_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner_oh[i]) begin
        owner_data = slice[i];
      end
    end
  end

  assign owner_req = |(req & owner_oh);

  // The FIFO stalls when it is full. It also stalls when it is almost full
  // and a write is already on its way to the FIFO.
  assign stall     = fifo_full | (fifo_almostfull & wr_en_q);
  assign xfer      = (state_q == S_WRITE) & owner_req & ~stall;
  assign last_beat = (beat_cnt_q == 4'(BURST - 1));
  assign owner_next = (owner_q == 3'(N_REQ - 1)) ? 3'd0 : owner_q + 3'd1;

  logic [2:0] pick;
  logic       found;
  logic [3:0] cand;

  // Round-robin search: the first active request at or above rr_ptr, wrapping.
  always_comb begin
    pick  = 3'd0;
    found = 1'b0;
    cand  = 4'd0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + 4'(k);
      if (cand >= 4'(N_REQ)) begin
        cand = cand - 4'(N_REQ);
      end
      for (int j = 0; j < N_REQ; j++) begin
        if (!found && (cand == 4'(j)) && req[j]) begin
          found = 1'b1;
          pick  = 3'(j);
        end
      end
    end
  end

  // Grant only the owner, and only while the FIFO can accept the beat.
  always_comb begin
    gnt = '0;
    if ((state_q == S_WRITE) && !stall) begin
      gnt = req & owner_oh;
    end
  end

  // Next-state logic for the arbitration FSM and its datapath registers.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    wr_en_d     = 1'b0;
    data_d      = data_q;
    stall_cnt_d = stall_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d    = S_WRITE;
          owner_d    = pick;
          beat_cnt_d = 4'd0;
        end
      end

      S_WRITE: begin
        if (owner_req && stall && (stall_cnt_q != 16'hFFFF)) begin
          stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (xfer) begin
          wr_en_d    = 1'b1;
          data_d     = owner_data;
          beat_cnt_d = beat_cnt_q + 4'd1;
        end
        // A stall alone never ends the burst. Only a full burst ends it,
        // or the owner dropping its request.
        if ((xfer && last_beat) || !owner_req) begin
          state_d  = S_IDLE;
          rr_ptr_d = owner_next;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset clears them immediately,
  // without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      owner_q     <= 3'd0;
      rr_ptr_q    <= 3'd0;
      beat_cnt_q  <= 4'd0;
      wr_en_q     <= 1'b0;
      data_q      <= '0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      wr_en_q     <= wr_en_d;
      data_q      <= data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fifo_wr_en   = wr_en_q;
  assign fifo_data_in = data_q;
  assign stall_cnt    = stall_cnt_q;
  assign owner_id     = owner_q;

endmodule
